// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared types for the DM port sequencer.
// Optional alignment/range checking is enabled with MEM_ALIGN_CHECK_EN.
package mem_port_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int DEF_IMEM_BYTES = 32;
  localparam int DEF_DMEM_BYTES = 64;
  localparam int WAIT_W         = 4;

  typedef logic [WAIT_W-1:0] wait_t;

  typedef struct packed {
    logic        iord;
    logic        store;
    logic        err;
    logic [31:0] addr;
  } xlate_t;

endpackage

// File: rtl/mem_addr_xlate.sv
// mem_addr_xlate: byte address to DM Addr/IorD translation.
// MEM_ALIGN_CHECK_EN adds error detection; otherwise addresses wrap.
import mem_port_pkg::*;

module mem_addr_xlate #(
  parameter int IMEM_BYTES = DEF_IMEM_BYTES,
  parameter int DMEM_BYTES = DEF_DMEM_BYTES
) (
  input  logic        we,
  input  logic        ifetch,
  input  logic [31:0] addr,
  output xlate_t      x
);

  localparam logic [31:0] IMEM_L = 32'(IMEM_BYTES);
  localparam logic [31:0] DMEM_L = 32'(DMEM_BYTES);

`ifdef MEM_ALIGN_CHECK_EN

  // Reject misaligned, out-of-region and store-to-instruction requests
  always_comb begin
    x.iord  = ifetch;
    x.store = we & ~ifetch;
    x.err   = (addr[1:0] != 2'b00)
            | (ifetch & (addr >= IMEM_L))
            | (~ifetch & (addr >= DMEM_L))
            | (we & ifetch);
    if (ifetch)
      x.addr = addr >> 2;
    else if (we)
      x.addr = (IMEM_L + addr) >> 2;
    else
      x.addr = addr;
  end

`else

  logic [31:0] a_al;
  logic        unused_lsb;

  assign a_al       = {addr[31:2], 2'b00};
  assign unused_lsb = ^addr[1:0];

  // Force word alignment and wrap into the region; we&ifetch reads
  always_comb begin
    x.iord  = ifetch;
    x.store = we & ~ifetch;
    x.err   = 1'b0;
    if (ifetch)
      x.addr = (a_al % IMEM_L) >> 2;
    else if (we)
      x.addr = (IMEM_L + (a_al % DMEM_L)) >> 2;
    else
      x.addr = a_al % DMEM_L;
  end

`endif

endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: one-at-a-time fetch/load/store sequencer in front of DM.
// Define MEM_ALIGN_CHECK_EN to reject bad requests with resp_err.
import mem_port_pkg::*;

module mem_port_ctrl #(
  parameter int IMEM_BYTES  = DEF_IMEM_BYTES,
  parameter int DMEM_BYTES  = DEF_DMEM_BYTES,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_ifetch,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        dm_R,
  output logic        dm_W,
  output logic        dm_IorD,
  output logic [31:0] dm_Addr,
  output logic [31:0] dm_W_data,
  input  logic [31:0] dm_R_data
);

  localparam wait_t WAIT_INIT = wait_t'(WAIT_CYCLES);

  state_t state;
  wait_t  cnt;
  logic   op_store;
  logic   op_fetch;
  xlate_t x;

  mem_addr_xlate #(
    .IMEM_BYTES (IMEM_BYTES),
    .DMEM_BYTES (DMEM_BYTES)
  ) u_xlate (
    .we     (req_we),
    .ifetch (req_ifetch),
    .addr   (req_addr),
    .x      (x)
  );

  // Request sequencer with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_store   <= 1'b0;
      op_fetch   <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      ir         <= '0;
      mdr        <= '0;
      dm_R       <= 1'b0;
      dm_W       <= 1'b0;
      dm_IorD    <= 1'b0;
      dm_Addr    <= '0;
      dm_W_data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            cnt       <= WAIT_INIT;
            op_store  <= x.store;
            op_fetch  <= req_ifetch;
            if (x.err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state     <= S_ACCESS;
              dm_IorD   <= x.iord;
              dm_Addr   <= x.addr;
              dm_R      <= ~x.store;
              dm_W      <= x.store && (WAIT_CYCLES == 0);
              dm_W_data <= x.store ? req_wdata : '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (op_fetch)
              ir <= dm_R_data;
            else if (!op_store)
              mdr <= dm_R_data;
            state      <= S_RESP;
            resp_valid <= 1'b1;
            dm_R       <= 1'b0;
            dm_W       <= 1'b0;
            dm_IorD    <= 1'b0;
            dm_Addr    <= '0;
            dm_W_data  <= '0;
          end else begin
            cnt  <= cnt - wait_t'(1);
            dm_W <= op_store && (cnt == wait_t'(1));
          end
        end
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: directed plus random requests against two DUTs
// (WAIT_CYCLES=1 and 0) with a word-level memory reference model.
module tb_mem_port_ctrl;

  localparam int IMEM = 32;
  localparam int DMEM = 64;
  localparam int NW   = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0;
  logic        sel = 1'b0;
  logic        r_we = 1'b0;
  logic        r_if = 1'b0;
  logic [31:0] r_addr = '0;
  logic [31:0] r_wd = '0;

  logic        a_valid, a_ready, a_rv, a_rerr, a_R, a_W, a_iord;
  logic [31:0] a_ir, a_mdr, a_addr, a_wd, a_rd;
  logic        b_valid, b_ready, b_rv, b_rerr, b_R, b_W, b_iord;
  logic [31:0] b_ir, b_mdr, b_addr, b_wd, b_rd;

  logic        o_ready, o_rv, o_rerr, o_R, o_W, o_iord;
  logic [31:0] o_ir, o_mdr, o_addr, o_wd;

  logic [31:0] mem  [2][NW];
  logic [31:0] refm [2][NW];
  logic [31:0] exp_ir [2];
  logic [31:0] exp_mdr [2];
  int          acc [2];
  int          wtot [2];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign a_valid = rv & ~sel;
  assign b_valid = rv & sel;

  assign o_ready = sel ? b_ready : a_ready;
  assign o_rv    = sel ? b_rv    : a_rv;
  assign o_rerr  = sel ? b_rerr  : a_rerr;
  assign o_R     = sel ? b_R     : a_R;
  assign o_W     = sel ? b_W     : a_W;
  assign o_iord  = sel ? b_iord  : a_iord;
  assign o_ir    = sel ? b_ir    : a_ir;
  assign o_mdr   = sel ? b_mdr   : a_mdr;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_wd    = sel ? b_wd    : a_wd;

  // DM model: IorD=1 word index, read IorD=0 data byte offset,
  // write uses the word index directly
  function automatic logic [31:0] ridx(logic iord, logic [31:0] ad);
    if (iord) return ad % NW;
    return ((IMEM + ad) / 4) % NW;
  endfunction

  assign a_rd = mem[0][ridx(a_iord, a_addr)];
  assign b_rd = mem[1][ridx(b_iord, b_addr)];

  always @(posedge clk) begin
    if (a_W) begin
      mem[0][a_addr % NW] = a_wd;
      wtot[0]++;
    end
    if (b_W) begin
      mem[1][b_addr % NW] = b_wd;
      wtot[1]++;
    end
    if (!rst && a_valid && a_ready) acc[0]++;
    if (!rst && b_valid && b_ready) acc[1]++;
  end

  mem_port_ctrl #(
    .IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .WAIT_CYCLES(1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_we(r_we), .req_ifetch(r_if),
    .req_addr(r_addr), .req_wdata(r_wd),
    .resp_valid(a_rv), .resp_err(a_rerr),
    .ir(a_ir), .mdr(a_mdr),
    .dm_R(a_R), .dm_W(a_W), .dm_IorD(a_iord),
    .dm_Addr(a_addr), .dm_W_data(a_wd), .dm_R_data(a_rd)
  );

  mem_port_ctrl #(
    .IMEM_BYTES(IMEM), .DMEM_BYTES(DMEM), .WAIT_CYCLES(0)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_we(r_we), .req_ifetch(r_if),
    .req_addr(r_addr), .req_wdata(r_wd),
    .resp_valid(b_rv), .resp_err(b_rerr),
    .ir(b_ir), .mdr(b_mdr),
    .dm_R(b_R), .dm_W(b_W), .dm_IorD(b_iord),
    .dm_Addr(b_addr), .dm_W_data(b_wd), .dm_R_data(b_rd)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_flags"}, {26'd0, o_ready, o_rv, o_rerr, o_R, o_W, o_iord},
        32'b100000);
    chk({tag, "_ir"}, o_ir, 32'd0);
    chk({tag, "_mdr"}, o_mdr, 32'd0);
    chk({tag, "_addr"}, o_addr, 32'd0);
    chk({tag, "_wdata"}, o_wd, 32'd0);
  endtask

  // One request: the caller is at a negedge; returns at the
  // negedge of the response cycle
  task automatic run(bit s, bit we, bit ifx, logic [31:0] ad,
                     logic [31:0] wd, bit keep);
    int          w;
    bit          err, is_f, is_st, idle_bad;
    logic [31:0] al, idx, eaddr, sa, swd;
    logic        eiord, siord;
    int          n, a0, lat, rc, wc, nrdy;
    w  = s ? 0 : 1;
    al = ad & 32'hFFFF_FFFC;
`ifdef MEM_ALIGN_CHECK_EN
    err = (ad[1:0] != 2'b00) || (ifx && ad >= IMEM) ||
          (!ifx && ad >= DMEM) || (we && ifx);
`else
    err = 1'b0;
`endif
    is_f  = ifx;
    is_st = we && !ifx;
    if (is_f) begin
      idx   = (al % IMEM) / 4;
      eaddr = idx;
      eiord = 1'b1;
    end else if (is_st) begin
      idx   = IMEM / 4 + (al % DMEM) / 4;
      eaddr = idx;
      eiord = 1'b0;
    end else begin
      idx   = IMEM / 4 + (al % DMEM) / 4;
      eaddr = al % DMEM;
      eiord = 1'b0;
    end

    sel = s; r_we = we; r_if = ifx; r_addr = ad; r_wd = wd; rv = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", {31'd0, o_ready}, 32'd1);
      rv = 1'b0;
      return;
    end
    a0 = acc[s];
    @(posedge clk);
    #1;
    if (!keep) rv = 1'b0;
    lat = 0; rc = 0; wc = 0; nrdy = 0; idle_bad = 1'b0;
    sa = '0; swd = '0; siord = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (o_ready) nrdy++;
      if (o_R) rc++;
      if (o_W) begin
        wc++;
        swd = o_wd;
      end
      if (o_R || o_W) begin
        sa    = o_addr;
        siord = o_iord;
      end
      if (o_rv) begin
        lat = j;
        if (o_R || o_W || o_iord || o_addr != 0 || o_wd != 0)
          idle_bad = 1'b1;
        break;
      end
    end
    chk("accept_once", 32'(acc[s] - a0), 32'd1);
    chk("latency", 32'(lat), err ? 32'd1 : 32'(w + 2));
    chk("resp_err", {31'd0, o_rerr}, {31'd0, err});
    chk("rd_cycles", 32'(rc), (err || is_st) ? 32'd0 : 32'(w + 1));
    chk("wr_cycles", 32'(wc), (!err && is_st) ? 32'd1 : 32'd0);
    chk("ready_busy", 32'(nrdy), 32'd0);
    chk("resp_dm_idle", {31'd0, idle_bad}, 32'd0);
    if (!err) begin
      chk("dm_addr", sa, eaddr);
      chk("dm_iord", {31'd0, siord}, {31'd0, eiord});
    end
    if (!err && is_st) begin
      chk("dm_wdata", swd, wd);
      refm[s][idx] = wd;
    end
    if (!err && is_f) exp_ir[s] = refm[s][idx];
    if (!err && !is_f && !is_st) exp_mdr[s] = refm[s][idx];
    chk("ir", o_ir, exp_ir[s]);
    chk("mdr", o_mdr, exp_mdr[s]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, w0;
    bit          s, we, ifx;
    logic [31:0] ad;
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0;
      wtot[k] = 0;
      exp_ir[k] = '0;
      exp_mdr[k] = '0;
      for (int i = 0; i < NW; i++) begin
        mem[k][i]  = $urandom;
        refm[k][i] = mem[k][i];
      end
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;
    #1;
    chk_reset_outputs("reset_a");
    sel = 1'b1;
    #1;
    chk_reset_outputs("reset_b");
    sel = 1'b0;
    @(negedge clk);

    // Fetch at 0x8, then store/load round trip
    run(0, 0, 1, 32'h8, 32'h0, 0);
    run(0, 1, 0, 32'h4, 32'hDEADBEEF, 0);
    run(0, 0, 0, 32'h4, 32'h0, 0);
    chk("load_after_store", o_mdr, 32'hDEADBEEF);

    // Back-to-back with req_valid held high
    w0 = acc[0];
    run(0, 0, 1, 32'h10, 32'h0, 1);
    run(0, 1, 0, 32'h20, $urandom, 1);
    run(0, 0, 0, 32'h20, 32'h0, 0);
    chk("b2b_accepts", 32'(acc[0] - w0), 32'd3);

`ifdef MEM_ALIGN_CHECK_EN
    run(0, 0, 0, 32'h42, 32'h0, 0);
    run(0, 0, 1, 32'h20, 32'h0, 0);
    run(0, 0, 0, 32'h40, 32'h0, 0);
    run(0, 1, 1, 32'h4, 32'h12345678, 0);
`else
    run(0, 0, 1, 32'h23, 32'h0, 0);
    run(0, 0, 0, 32'h45, 32'h0, 0);
    run(0, 1, 0, 32'h7F, 32'h0BADF00D, 0);
    run(0, 1, 1, 32'h4, 32'h12345678, 0);
`endif

    // Reset in the first ACCESS cycle of a store
    sel = 1'b0; r_we = 1'b1; r_if = 1'b0;
    r_addr = 32'h10; r_wd = 32'hCAFEF00D; rv = 1'b1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    w0 = wtot[0];
    @(posedge clk);
    #1 rv = 1'b0;
    @(negedge clk);
    chk("rst_pre_w", {31'd0, o_W}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("rst_abort");
    for (int k = 0; k < 2; k++) begin
      exp_ir[k] = '0;
      exp_mdr[k] = '0;
    end
    @(negedge clk);
    chk("rst_ready_next", {31'd0, o_ready}, 32'd1);
    repeat (3) @(negedge clk);
    chk("rst_no_write", 32'(wtot[0] - w0), 32'd0);
    chk("rst_word_kept", mem[0][12], refm[0][12]);

    // Zero wait-state instance
    run(1, 0, 0, 32'h3C, 32'h0, 0);
    chk("last_word", o_mdr, refm[1][NW-1]);
    run(1, 1, 0, 32'h8, $urandom, 0);
    run(1, 0, 1, 32'h1C, 32'h0, 0);

    // Random traffic across both instances
    for (int i = 0; i < 40; i++) begin
      s   = 1'($urandom % 2);
      we  = 1'($urandom % 2);
      ifx = ($urandom % 3) == 0;
      if ($urandom % 4 == 0)
        ad = $urandom_range(0, 127);
      else if (ifx)
        ad = 32'($urandom_range(0, IMEM / 4 - 1)) * 4;
      else
        ad = 32'($urandom_range(0, DMEM / 4 - 1)) * 4;
      run(s, we, ifx, ad, $urandom, (i != 39) && ($urandom % 2 == 1));
    end

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NW; i++)
        chk("mem_final", mem[k][i], refm[k][i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
